// File: rtl/i2s_tx.sv
// I2S transmitter: one-entry stereo buffer with valid/ready intake,
// serialised as BCLK/LRCLK/SDATA with the one-bit I2S delay.
//
// Ports:
//   clk, reset_n        system clock, async active-low reset
//   enable              0 = synchronous return to reset state
//   sample_l, sample_r  signed PCM pair (passed bit-exact)
//   sample_valid        pair offered
//   sample_ready        buffer empty; pair taken this cycle if valid
//   bclk, lrclk, sdata  I2S pins (lrclk 0 = left, sdata MSB first)
//   underrun            one-clk pulse when a frame starts unfed
module i2s_tx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_BITS    = 32,
  parameter int CLK_DIV      = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] sample_l,
  input  logic [SAMPLE_WIDTH-1:0] sample_r,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    underrun
);

  localparam int FB  = 2 * SLOT_BITS;
  localparam int BW  = $clog2(FB);
  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PAD = SLOT_BITS - SAMPLE_WIDTH;

  localparam logic [BW-1:0] LAST    = BW'(FB - 1);
  localparam logic [BW-1:0] HALF    = BW'(SLOT_BITS);
  localparam logic [DW-1:0] DIV_TOP = DW'(CLK_DIV - 1);

  logic [DW-1:0]           div_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [BW-1:0]           bit_nxt;
  logic [BW-1:0]           bit_idx;
  logic                    buf_full;
  logic                    full_nxt;
  logic                    div_wrap;
  logic                    shift;
  logic                    frame_start;
  logic                    accept;
  logic [SAMPLE_WIDTH-1:0] buf_l;
  logic [SAMPLE_WIDTH-1:0] buf_r;
  logic [SAMPLE_WIDTH-1:0] frame_l;
  logic [SAMPLE_WIDTH-1:0] frame_r;
  logic [SLOT_BITS-1:0]    slot_l;
  logic [SLOT_BITS-1:0]    slot_r;
  logic [FB-1:0]           frame_bits;

  always_comb begin
    slot_l      = SLOT_BITS'(frame_l) << PAD;
    slot_r      = SLOT_BITS'(frame_r) << PAD;
    frame_bits  = {slot_l, slot_r};
    div_wrap    = (div_cnt == DIV_TOP);
    shift       = bclk && div_wrap;
    bit_nxt     = (bit_cnt == LAST) ? '0 : bit_cnt + BW'(1);
    // old bit_cnt is the frame position sdata carries next
    bit_idx     = LAST - bit_cnt;
    frame_start = shift && (bit_cnt == LAST);
    accept      = sample_valid && sample_ready;
    full_nxt    = buf_full;
    if (frame_start) full_nxt = 1'b0;
    if (accept)      full_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt      <= '0;
      bit_cnt      <= LAST;
      bclk         <= 1'b0;
      lrclk        <= 1'b1;
      sdata        <= 1'b0;
      sample_ready <= 1'b0;
      underrun     <= 1'b0;
      buf_full     <= 1'b0;
      buf_l        <= '0;
      buf_r        <= '0;
      frame_l      <= '0;
      frame_r      <= '0;
    end else if (!enable) begin
      div_cnt      <= '0;
      bit_cnt      <= LAST;
      bclk         <= 1'b0;
      lrclk        <= 1'b1;
      sdata        <= 1'b0;
      sample_ready <= 1'b0;
      underrun     <= 1'b0;
      buf_full     <= 1'b0;
      buf_l        <= '0;
      buf_r        <= '0;
      frame_l      <= '0;
      frame_r      <= '0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + DW'(1);
      if (div_wrap) bclk <= !bclk;
      if (shift) begin
        bit_cnt <= bit_nxt;
        lrclk   <= (bit_nxt >= HALF);
        sdata   <= frame_bits[bit_idx];
      end
      if (frame_start) begin
        frame_l <= buf_full ? buf_l : '0;
        frame_r <= buf_full ? buf_r : '0;
      end
      if (accept) begin
        buf_l <= sample_l;
        buf_r <= sample_r;
      end
      buf_full     <= full_nxt;
      sample_ready <= !full_nxt;
      underrun     <= frame_start && !buf_full;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: two instances (16- and 24-bit slots, CLK_DIV=2)
// checked each cycle against a frame-timing model plus literals.
module tb_i2s_tx;

  localparam int CD = 2;

  logic        clk;
  logic        rst_n [2];
  logic        en [2];
  logic        valid [2];
  logic [15:0] sl [2];
  logic [15:0] sr [2];
  logic        ready [2];
  logic        bclk [2];
  logic        lrclk [2];
  logic        sdata [2];
  logic        und [2];

  int checks = 0;
  int errors = 0;

  i2s_tx #(.SAMPLE_WIDTH(16), .SLOT_BITS(16), .CLK_DIV(CD)) u0 (
    .clk(clk), .reset_n(rst_n[0]), .enable(en[0]),
    .sample_l(sl[0]), .sample_r(sr[0]), .sample_valid(valid[0]),
    .sample_ready(ready[0]), .bclk(bclk[0]), .lrclk(lrclk[0]),
    .sdata(sdata[0]), .underrun(und[0])
  );

  i2s_tx #(.SAMPLE_WIDTH(16), .SLOT_BITS(24), .CLK_DIV(CD)) u1 (
    .clk(clk), .reset_n(rst_n[1]), .enable(en[1]),
    .sample_l(sl[1]), .sample_r(sr[1]), .sample_valid(valid[1]),
    .sample_ready(ready[1]), .bclk(bclk[1]), .lrclk(lrclk[1]),
    .sdata(sdata[1]), .underrun(und[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sb(int i);
    return (i == 0) ? 16 : 24;
  endfunction

  // model: t = enabled clk edges since (re)start; frames in history
  int       t [2];
  bit       mfull [2];
  bit       mrdy [2];
  bit       mund [2];
  int       nfr [2];
  bit [15:0] mbl [2];
  bit [15:0] mbr [2];
  bit [15:0] hl [2][64];
  bit [15:0] hr [2][64];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i] || !en[i]) begin
        t[i] = 0; mfull[i] = 0; mrdy[i] = 0; mund[i] = 0; nfr[i] = 0;
      end else begin
        bit acc;
        int k;
        acc = valid[i] && mrdy[i];
        t[i]++;
        mund[i] = 0;
        if (t[i] % (2 * CD) == 0) begin
          k = t[i] / (2 * CD);
          if ((k - 1) % (2 * sb(i)) == 0) begin
            hl[i][nfr[i] % 64] = mfull[i] ? mbl[i] : 16'h0;
            hr[i][nfr[i] % 64] = mfull[i] ? mbr[i] : 16'h0;
            mund[i] = !mfull[i];
            mfull[i] = 0;
            nfr[i]++;
          end
        end
        if (acc) begin
          mfull[i] = 1; mbl[i] = sl[i]; mbr[i] = sr[i];
        end
        mrdy[i] = !mfull[i];
      end
    end
  end

  // {bclk, lrclk, sdata, ready, underrun} expected after t edges
  function automatic logic [4:0] expv(int i);
    int k, s, g, f, p, q;
    bit [15:0] smp;
    logic b, lr, sd;
    s  = sb(i);
    b  = ((t[i] / CD) % 2) == 1;
    k  = t[i] / (2 * CD);
    lr = 1'b1;
    sd = 1'b0;
    if (k > 0) begin
      lr = ((k - 1) % (2 * s)) >= s;
      g = k - 2;
      if (g >= 0) begin
        f = g / (2 * s);
        p = g % (2 * s);
        smp = (p >= s) ? hr[i][f % 64] : hl[i][f % 64];
        q = p % s;
        if (q < 16) sd = smp[15 - q];
      end
    end
    return {b, lr, sd, mrdy[i], mund[i]};
  endfunction

  function automatic logic [4:0] outs(int i);
    return {bclk[i], lrclk[i], sdata[i], ready[i], und[i]};
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (outs(i) !== expv(i)) begin
          errors++;
          $display("FAIL outs%0d at %0t: got %b, want %b",
                   i, $time, outs(i), expv(i));
        end
      end
    end
  endtask

  // capture frames as seen on BCLK rises; a push happens at the rise
  // carrying the previous frame's last bit
  logic [63:0] shr [2];
  logic [63:0] cap [2][64];
  int          ncap [2];
  bit          plr [2];
  int          und_n [2];

  task automatic cap_step(int i);
    shr[i] = {shr[i][62:0], sdata[i]};
    if (!lrclk[i] && plr[i]) begin
      cap[i][ncap[i] % 64] = shr[i];
      ncap[i]++;
    end
    plr[i] = lrclk[i];
  endtask

  initial begin
    ncap[0] = 0; ncap[1] = 0; plr[0] = 1; plr[1] = 1;
    shr[0] = '0; shr[1] = '0;
  end
  always @(posedge bclk[0]) cap_step(0);
  always @(posedge bclk[1]) cap_step(1);

  initial begin
    und_n[0] = 0; und_n[1] = 0;
  end
  always @(negedge clk) begin
    if (und[0] === 1'b1) und_n[0]++;
    if (und[1] === 1'b1) und_n[1]++;
  end

  task automatic run_to(int i, int n);
    while (t[i] < n) @(negedge clk);
  endtask

  task automatic start(int i);
    en[i] = 1'b0;
    @(negedge clk);
    en[i] = 1'b1;
  endtask

  task automatic offer(int i, logic [15:0] l, logic [15:0] r);
    bit ok;
    ok = 0;
    sl[i] = l; sr[i] = r; valid[i] = 1'b1;
    for (int n = 0; n < 500; n++) begin
      if (ready[i]) begin
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    valid[i] = 1'b0;
    chk("offer_accepted", 64'(ok), 64'd1);
  endtask

  task automatic lr_period(int i, output int p);
    logic prev;
    bit found;
    p = -1;
    found = 0;
    prev = lrclk[i];
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (lrclk[i] && !prev) begin found = 1; break; end
      prev = lrclk[i];
    end
    prev = 1'b1;
    if (found) begin
      for (int c = 1; c < 1000; c++) begin
        @(negedge clk);
        if (lrclk[i] && !prev) begin p = c; break; end
        prev = lrclk[i];
      end
    end
  endtask

  int b, u, acc, per;
  logic [15:0] n;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 0; en[i] = 0; valid[i] = 0; sl[i] = 0; sr[i] = 0;
    end
    fork
      compare_loop();
    join_none
    repeat (2) @(negedge clk);
    chk("reset0", 64'(outs(0)), 64'b01000);
    chk("reset1", 64'(outs(1)), 64'b01000);
    rst_n[0] = 1; rst_n[1] = 1;
    @(negedge clk);

    // basic frame then underrun frame
    b = ncap[0]; u = und_n[0];
    start(0);
    offer(0, 16'hA5F0, 16'h0F0F);
    run_to(0, 200);
    chk("t1_frame", 64'(cap[0][(b + 1) % 64][31:0]), 64'hA5F00F0F);
    chk("t1_underruns", 64'(und_n[0] - u), 64'd1);

    // no data at all
    b = ncap[0]; u = und_n[0];
    start(0);
    run_to(0, 520);
    chk("t2_underruns", 64'(und_n[0] - u), 64'd5);
    for (int f = 1; f <= 3; f++)
      chk("t2_zero_frame", 64'(cap[0][(b + f) % 64][31:0]), 64'd0);

    // back-pressure with incrementing pairs
    b = ncap[0]; u = und_n[0]; acc = 0; n = 0;
    start(0);
    sl[0] = n; sr[0] = ~n; valid[0] = 1'b1;
    while (t[0] < 768) begin
      if (ready[0]) begin
        acc++;
        @(negedge clk);
        n++;
        sl[0] = n; sr[0] = ~n;
      end else begin
        @(negedge clk);
      end
    end
    valid[0] = 1'b0;
    chk("t3_accepts", 64'(acc), 64'd7);
    chk("t3_underruns", 64'(und_n[0] - u), 64'd0);
    for (int f = 0; f < 5; f++)
      chk("t3_frame", 64'(cap[0][(b + 1 + f) % 64][31:0]),
          64'({16'(f), ~16'(f)}));
    en[0] = 1'b0;

    // 24-bit slot padding
    b = ncap[1]; u = und_n[1];
    start(1);
    offer(1, 16'h8001, 16'h1234);
    run_to(1, 260);
    chk("t4_frame", 64'(cap[1][(b + 1) % 64][47:0]), 64'h8001_00_1234_00);
    chk("t4_underruns", 64'(und_n[1] - u), 64'd1);
    lr_period(1, per);
    chk("t4_lr_period", 64'(per), 64'd192);
    en[1] = 1'b0;

    // async reset at bit_cnt=7 of the left slot
    start(0);
    offer(0, 16'h1111, 16'h2222);
    run_to(0, 33);
    #2 rst_n[0] = 1'b0;
    #1 chk("t5_reset_now", 64'(outs(0)), 64'b01000);
    @(negedge clk);
    @(negedge clk);
    b = ncap[0]; u = und_n[0];
    rst_n[0] = 1'b1;
    offer(0, 16'h3C3C, 16'hC3C3);
    run_to(0, 140);
    chk("t5_frame", 64'(cap[0][(b + 1) % 64][31:0]), 64'h3C3CC3C3);
    chk("t5_underruns", 64'(und_n[0] - u), 64'd1);

    // disable with a full buffer
    start(0);
    offer(0, 16'h5555, 16'hAAAA);
    offer(0, 16'h7777, 16'h8888);
    run_to(0, 40);
    en[0] = 1'b0;
    @(posedge clk);
    #1 chk("t6_disabled", 64'(outs(0)), 64'b01000);
    @(negedge clk);
    b = ncap[0]; u = und_n[0];
    en[0] = 1'b1;
    run_to(0, 140);
    chk("t6_underruns", 64'(und_n[0] - u), 64'd2);
    chk("t6_frame", 64'(cap[0][(b + 1) % 64][31:0]), 64'd0);
    en[0] = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
